// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha block I/O sequencer and the per-column quarter slices.
package chacha_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        RUN    = 2'd1,
        UNLOAD = 2'd2
    } blk_state_e;

    localparam logic [5:0] LOAD_BASE   = 6'd16;
    localparam int         LOAD_BYTES  = 48;
    localparam int         BLOCK_BYTES = 64;

    localparam logic [5:0] LOAD_LAST  = 6'(LOAD_BYTES - 1);
    localparam logic [5:0] BLOCK_LAST = 6'(BLOCK_BYTES - 1);

    // Byte address layout {row, col, byte}, shared with the slices.
    localparam int ADDR_ROW_HI  = 5;
    localparam int ADDR_ROW_LO  = 4;
    localparam int ADDR_COL_HI  = 3;
    localparam int ADDR_COL_LO  = 2;
    localparam int ADDR_BYTE_HI = 1;
    localparam int ADDR_BYTE_LO = 0;

    function automatic logic [5:0] load_addr(input logic [5:0] cnt);
        return LOAD_BASE + cnt;
    endfunction

endpackage

// File: rtl/chacha_out_stage.sv
// One-entry valid/ready output register; accepts a new byte whenever it is empty or being drained.
module chacha_out_stage
    import chacha_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_en,
    input  logic [7:0] din,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       can_load
);

    logic [7:0] data_r;
    logic       valid_r;
    logic       load_s;

    // Load-enable qualification: never overwrite a byte that is stalled downstream.
    always_comb begin
        can_load = 1'b0;
        load_s   = 1'b0;
        can_load = !valid_r || out_ready;
        load_s   = load_en && can_load;
    end

    // Holding register: capture on load, drop valid once the byte is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r  <= 8'h00;
            valid_r <= 1'b0;
        end else if (load_s) begin
            data_r  <= din;
            valid_r <= 1'b1;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_data  = data_r;
    assign out_valid = valid_r;

endmodule

// File: rtl/chacha_block_io.sv
// Host-side sequencer: loads key/counter/nonce into state rows 1-3, releases the core for a
// fixed compute window, then streams all 64 state bytes out through a valid/ready port.
module chacha_block_io
    import chacha_pkg::*;
#(
    parameter int CALC_CYCLES = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] blk_addr,
    output logic       blk_write,
    output logic [7:0] blk_wdata,
    input  logic [7:0] blk_rdata,
    output logic       blk_hold,
    output logic       blk_rst,
    output logic       busy
);

    // Width stays at least 1 so CALC_CYCLES == 0 still elaborates a (constant) counter.
    localparam int            CW        = (CALC_CYCLES > 0) ? $clog2(CALC_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CALC_LAST = (CALC_CYCLES > 0) ? CW'(CALC_CYCLES - 1) : {CW{1'b0}};
    localparam logic          RUN_HOLD  = (CALC_CYCLES == 0) ? 1'b1 : 1'b0;

    blk_state_e    state_r;
    blk_state_e    state_nxt_s;
    logic [5:0]    load_cnt_r;
    logic [CW-1:0] calc_cnt_r;
    logic [5:0]    rd_cnt_r;
    logic          rd_done_r;
    logic          blk_rst_r;

    logic          in_ready_s;
    logic          accept_s;
    logic          load_last_s;
    logic          run_done_s;
    logic          capture_s;
    logic          finish_s;
    logic          can_load_s;
    logic          out_valid_s;

    // Handshake qualifiers for the load and unload sides.
    always_comb begin
        in_ready_s  = 1'b0;
        accept_s    = 1'b0;
        load_last_s = 1'b0;
        run_done_s  = 1'b0;
        capture_s   = 1'b0;
        finish_s    = 1'b0;
        in_ready_s  = (state_r == LOAD) && !blk_rst_r;
        accept_s    = in_valid && in_ready_s;
        load_last_s = accept_s && (load_cnt_r == LOAD_LAST);
        run_done_s  = (state_r == RUN) && (calc_cnt_r == CALC_LAST);
        capture_s   = (state_r == UNLOAD) && !rd_done_r && can_load_s;
        finish_s    = (state_r == UNLOAD) && rd_done_r && out_valid_s && out_ready;
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LOAD: begin
                if (load_last_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            RUN: begin
                if (run_done_s) begin
                    state_nxt_s = UNLOAD;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            UNLOAD: begin
                if (finish_s) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = UNLOAD;
                end
            end
            default: state_nxt_s = LOAD;
        endcase
    end

    // Slice bus drive: writes are combinational with the accept so load has zero latency.
    always_comb begin
        blk_addr  = 6'd0;
        blk_write = 1'b0;
        blk_wdata = 8'h00;
        blk_hold  = 1'b1;
        case (state_r)
            LOAD: begin
                blk_addr  = load_addr(load_cnt_r);
                blk_write = accept_s;
                if (accept_s) begin
                    blk_wdata = in_data;
                end else begin
                    blk_wdata = 8'h00;
                end
            end
            RUN: begin
                blk_hold = RUN_HOLD;
            end
            UNLOAD: begin
                blk_addr = rd_cnt_r;
            end
            default: begin
                blk_hold = 1'b1;
            end
        endcase
    end

    // State register and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= LOAD;
            load_cnt_r <= 6'd0;
            calc_cnt_r <= {CW{1'b0}};
            rd_cnt_r   <= 6'd0;
            rd_done_r  <= 1'b0;
            blk_rst_r  <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            blk_rst_r <= finish_s;

            if (load_last_s) begin
                load_cnt_r <= 6'd0;
            end else if (accept_s) begin
                load_cnt_r <= load_cnt_r + 6'd1;
            end else begin
                load_cnt_r <= load_cnt_r;
            end

            if ((state_r == RUN) && !run_done_s) begin
                calc_cnt_r <= calc_cnt_r + CW'(1);
            end else begin
                calc_cnt_r <= {CW{1'b0}};
            end

            // rd_done marks that address 63 has been captured; only the final handshake clears it.
            if (finish_s) begin
                rd_cnt_r  <= 6'd0;
                rd_done_r <= 1'b0;
            end else if (capture_s) begin
                rd_cnt_r  <= rd_cnt_r + 6'd1;
                rd_done_r <= (rd_cnt_r == BLOCK_LAST);
            end else begin
                rd_cnt_r  <= rd_cnt_r;
                rd_done_r <= rd_done_r;
            end
        end
    end

    chacha_out_stage u_out_stage (
        .clk       (clk),
        .rst       (rst),
        .load_en   (capture_s),
        .din       (blk_rdata),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid_s),
        .can_load  (can_load_s)
    );

    assign out_valid = out_valid_s;
    assign in_ready  = in_ready_s;
    assign blk_rst   = blk_rst_r;
    assign busy      = !((state_r == LOAD) && (load_cnt_r == 6'd0));

endmodule

// File: tb/tb_chacha_block_io.sv
// Scoreboard bench for chacha_block_io: a CALC_CYCLES=0 instance with behavioural slices for
// loopback, and a CALC_CYCLES=80 instance for the compute window.
module tb_chacha_block_io;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [7:0] in_data0, out_data0, blk_wdata0, blk_rdata0;
    logic       in_valid0, in_ready0, out_valid0, out_ready0;
    logic       blk_write0, blk_hold0, blk_rst0, busy0;
    logic [5:0] blk_addr0;

    logic [7:0] in_data80, out_data80, blk_wdata80, blk_rdata80;
    logic       in_valid80, in_ready80, out_valid80, out_ready80;
    logic       blk_write80, blk_hold80, blk_rst80, busy80;
    logic [5:0] blk_addr80;

    chacha_block_io #(.CALC_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
        .blk_addr(blk_addr0), .blk_write(blk_write0), .blk_wdata(blk_wdata0),
        .blk_rdata(blk_rdata0), .blk_hold(blk_hold0), .blk_rst(blk_rst0), .busy(busy0)
    );

    chacha_block_io #(.CALC_CYCLES(80)) dut80 (
        .clk(clk), .rst(rst), .in_data(in_data80), .in_valid(in_valid80), .in_ready(in_ready80),
        .out_data(out_data80), .out_valid(out_valid80), .out_ready(out_ready80),
        .blk_addr(blk_addr80), .blk_write(blk_write80), .blk_wdata(blk_wdata80),
        .blk_rdata(blk_rdata80), .blk_hold(blk_hold80), .blk_rst(blk_rst80), .busy(busy80)
    );

    // Behavioural slices: flat 64-byte state, row 0 re-initialised to the constants on blk_rst.
    logic [127:0] sigma_v = "expand 32-byte k";
    logic [7:0]   mem0 [64];

    always @(posedge clk) begin
        if (blk_rst0) begin
            for (int i = 0; i < 64; i++) mem0[i] <= (i < 16) ? sigma_v[8*(15-i) +: 8] : 8'h00;
        end else if (blk_write0) begin
            mem0[blk_addr0] <= blk_wdata0;
        end
    end

    assign blk_rdata0  = mem0[blk_addr0];
    assign blk_rdata80 = {2'b00, blk_addr80} ^ 8'h5A;

    logic [13:0] wr_q[$];
    logic [7:0]  out_q0[$];
    logic [7:0]  out_q80[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic load_bytes(input int n, input logic [7:0] xorv, input bit push_out);
        logic [13:0] exp;
        logic [7:0]  d;
        if (push_out) for (int i = 0; i < 16; i++) out_q0.push_back(sigma_v[8*(15-i) +: 8]);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d = i[7:0] ^ xorv;
            in_valid0 = 1'b1;
            in_data0  = d;
            wr_q.push_back({6'(16 + i), d});
            if (push_out) out_q0.push_back(d);
            #1;
            exp = wr_q.pop_front();
            n_checks++; if (blk_write0 !== 1'b1) $display("FAIL load_write[%0d]: got %b want 1", i, blk_write0); else n_pass++;
            n_checks++; if ({blk_addr0, blk_wdata0} !== exp) $display("FAIL load_addr_data[%0d]: got %h/%h want %h/%h", i, blk_addr0, blk_wdata0, exp[13:8], exp[7:0]); else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid0 = 1'b0; out_ready0 = 1'b0; in_data0 = 8'h00;
        in_valid80 = 1'b0; out_ready80 = 1'b0; in_data80 = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid0); else n_pass++;
        n_checks++; if (out_data0 !== 8'h00) $display("FAIL reset_out_data: got %h want 00", out_data0); else n_pass++;
        n_checks++; if (blk_hold0 !== 1'b1) $display("FAIL reset_hold: got %b want 1", blk_hold0); else n_pass++;
        n_checks++; if (blk_write0 !== 1'b0) $display("FAIL reset_write: got %b want 0", blk_write0); else n_pass++;
        n_checks++; if (blk_rst0 !== 1'b1) $display("FAIL reset_blk_rst: got %b want 1", blk_rst0); else n_pass++;
        n_checks++; if (in_ready0 !== 1'b0) $display("FAIL reset_in_ready_early: got %b want 0", in_ready0); else n_pass++;
        n_checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy0); else n_pass++;
        n_checks++; if ({blk_hold80, out_valid80, blk_rst80} !== 3'b101) $display("FAIL reset_dut80: got %b want 101", {blk_hold80, out_valid80, blk_rst80}); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (blk_rst0 !== 1'b0) $display("FAIL reset_blk_rst_drop: got %b want 0", blk_rst0); else n_pass++;
        n_checks++; if (in_ready0 !== 1'b1) $display("FAIL reset_in_ready_rise: got %b want 1", in_ready0); else n_pass++;
        n_checks++; if (in_ready80 !== 1'b1) $display("FAIL reset_in_ready80: got %b want 1", in_ready80); else n_pass++;
    endtask

    task automatic test_compute();
        int wr80 = 0, low = 0, hs = 0, cyc = 0;
        bit seen = 1'b0;
        logic [7:0] exp;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            in_valid80 = 1'b1; in_data80 = 8'(i + 3);
            #1;
            if (blk_write80 && blk_wdata80 == 8'(i + 3) && blk_addr80 == 6'(16 + i)) wr80++;
        end
        for (int a = 0; a < 64; a++) out_q80.push_back(8'(a) ^ 8'h5A);
        n_checks++; if (wr80 !== 48) $display("FAIL compute_load_writes: got %0d want 48", wr80); else n_pass++;
        out_ready80 = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            in_valid80 = 1'b0;
            #1;
            if (!blk_hold80) begin
                low++; seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        n_checks++; if (low !== 80) $display("FAIL compute_hold_low: got %0d want 80", low); else n_pass++;
        n_checks++; if (out_valid80 !== 1'b0) $display("FAIL compute_unload_first: got %b want 0", out_valid80); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (out_valid80 !== 1'b1) $display("FAIL compute_first_valid: got %b want 1", out_valid80); else n_pass++;
        while (hs < 64 && cyc < 200) begin
            if (out_valid80) begin
                exp = (out_q80.size() > 0) ? out_q80.pop_front() : 8'hxx;
                n_checks++; if (out_data80 !== exp) $display("FAIL compute_out[%0d]: got %h want %h", hs, out_data80, exp); else n_pass++;
                hs++;
            end
            @(negedge clk); #1;
            cyc++;
        end
        n_checks++; if (hs !== 64) $display("FAIL compute_handshakes: got %0d want 64", hs); else n_pass++;
        n_checks++; if ({out_valid80, blk_rst80} !== 2'b01) $display("FAIL compute_end: got %b want 01", {out_valid80, blk_rst80}); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (busy80 !== 1'b0) $display("FAIL compute_idle_busy: got %b want 0", busy80); else n_pass++;
    endtask

    task automatic test_load();
        load_bytes(48, 8'h00, 1'b1);
        @(negedge clk);
        in_valid0 = 1'b1; in_data0 = 8'hFF;
        #1;
        n_checks++; if (blk_write0 !== 1'b0) $display("FAIL run_ignore_write: got %b want 0", blk_write0); else n_pass++;
        n_checks++; if (in_ready0 !== 1'b0) $display("FAIL run_in_ready: got %b want 0", in_ready0); else n_pass++;
        n_checks++; if (busy0 !== 1'b1) $display("FAIL run_busy: got %b want 1", busy0); else n_pass++;
    endtask

    task automatic test_loopback();
        int hs = 0, cyc = 0, bad_wr = 0, bad_hold = 0;
        logic [7:0] exp;
        while (hs < 64 && cyc < 300) begin
            @(negedge clk);
            in_valid0 = 1'b1; out_ready0 = 1'b1;
            #1;
            if (blk_write0) bad_wr++;
            if (!blk_hold0) bad_hold++;
            if (out_valid0) begin
                exp = (out_q0.size() > 0) ? out_q0.pop_front() : 8'hxx;
                n_checks++; if (out_data0 !== exp) $display("FAIL loop_out[%0d]: got %h want %h", hs, out_data0, exp); else n_pass++;
                hs++;
            end
            cyc++;
        end
        n_checks++; if (hs !== 64) $display("FAIL loop_handshakes: got %0d want 64", hs); else n_pass++;
        n_checks++; if (cyc !== 65) $display("FAIL loop_unload_cycles: got %0d want 65", cyc); else n_pass++;
        n_checks++; if (bad_wr !== 0) $display("FAIL loop_stray_write: got %0d want 0", bad_wr); else n_pass++;
        n_checks++; if (bad_hold !== 0) $display("FAIL loop_hold_low: got %0d want 0", bad_hold); else n_pass++;
        @(negedge clk);
        in_valid0 = 1'b0;
        #1;
        n_checks++; if ({out_valid0, blk_rst0, in_ready0} !== 3'b010) $display("FAIL loop_end: got %b want 010", {out_valid0, blk_rst0, in_ready0}); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if ({blk_rst0, in_ready0, busy0} !== 3'b010) $display("FAIL loop_blk_rst_one: got %b want 010", {blk_rst0, in_ready0, busy0}); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int hs = 0, cyc = 0;
        bit stalled = 1'b0;
        logic [7:0] prev = 8'h00, exp;
        load_bytes(48, 8'hA5, 1'b1);
        while (hs < 64 && cyc < 600) begin
            @(negedge clk);
            in_valid0 = 1'b0; out_ready0 = pat[cyc % 4];
            #1;
            if (out_valid0) begin
                if (stalled) begin
                    n_checks++; if (out_data0 !== prev) $display("FAIL bp_stable[%0d]: got %h want %h", hs, out_data0, prev); else n_pass++;
                end
                if (out_ready0) begin
                    exp = (out_q0.size() > 0) ? out_q0.pop_front() : 8'hxx;
                    n_checks++; if (out_data0 !== exp) $display("FAIL bp_out[%0d]: got %h want %h", hs, out_data0, exp); else n_pass++;
                    hs++;
                end
            end
            stalled = out_valid0 && !out_ready0;
            prev = out_data0;
            cyc++;
        end
        n_checks++; if (hs !== 64) $display("FAIL bp_handshakes: got %0d want 64", hs); else n_pass++;
        n_checks++; if (out_q0.size() !== 0) $display("FAIL bp_leftover: got %0d want 0", out_q0.size()); else n_pass++;
        @(negedge clk);
        out_ready0 = 1'b0;
        #1;
        n_checks++; if ({out_valid0, blk_rst0} !== 2'b01) $display("FAIL bp_end: got %b want 01", {out_valid0, blk_rst0}); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int hs = 0, cyc = 0;
        logic [7:0] exp;
        load_bytes(20, 8'h3C, 1'b0);
        @(negedge clk);
        rst = 1'b1; in_valid0 = 1'b1; in_data0 = 8'h77;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if ({blk_write0, blk_rst0, busy0, out_valid0} !== 4'b0100) $display("FAIL midload_reset: got %b want 0100", {blk_write0, blk_rst0, busy0, out_valid0}); else n_pass++;
        load_bytes(48, 8'h5C, 1'b1);
        while (hs < 10 && cyc < 100) begin
            @(negedge clk);
            in_valid0 = 1'b0; out_ready0 = 1'b1;
            #1;
            if (out_valid0) begin
                exp = (out_q0.size() > 0) ? out_q0.pop_front() : 8'hxx;
                n_checks++; if (out_data0 !== exp) $display("FAIL mid_out[%0d]: got %h want %h", hs, out_data0, exp); else n_pass++;
                hs++;
            end
            cyc++;
        end
        n_checks++; if (hs !== 10) $display("FAIL mid_handshakes: got %0d want 10", hs); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if ({out_valid0, busy0, blk_rst0} !== 3'b001) $display("FAIL midunload_reset: got %b want 001", {out_valid0, busy0, blk_rst0}); else n_pass++;
        out_q0.delete();
        load_bytes(4, 8'h11, 1'b0);
        @(negedge clk);
        in_valid0 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_compute();
        test_load();
        test_loopback();
        test_backpressure();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/chacha_block_io.md
# chacha_block_io

Host-side sequencer for the ChaCha block state held in the per-column `quarter` slices. It streams 48 bytes (key, counter, nonce) into state rows 1–3 over the byte-addressed write bus. It then releases `hold` for a fixed number of compute cycles and streams all 64 state bytes back out through a valid/ready byte port. It is the other end of the `quarter` write/read bus: it generates `addr`, `write`, `data` and `hold`, and consumes the slices' OR-ed `data_out`.

## Interface

Parameters:
- `CALC_CYCLES`, default 80: number of cycles `blk_hold` is low per block. 0 is legal and means no compute phase.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `in_data` in 8: load byte from upstream.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts the byte this cycle.
- `out_data` out 8: state byte to downstream.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts this cycle.
- `blk_addr` out 6: state byte address `{row[1:0], col[1:0], byte[1:0]}`.
- `blk_write` out 1: write strobe to the slices.
- `blk_wdata` out 8: write data to the slices.
- `blk_rdata` in 8: OR of all slice `data_out`. Combinational in `blk_addr`.
- `blk_hold` out 1: pause the core when high.
- `blk_rst` out 1: active-high re-init request to the slices. The integrator inverts it into the slices' `rst_n`.
- `busy` out 1: high in any state other than LOAD-idle with `load_cnt == 0`.

## Operation

- States: LOAD → RUN → UNLOAD → LOAD.
- **LOAD**
  - `in_ready = (state == LOAD) && !blk_rst`.
  - On `in_valid && in_ready`: `blk_write = 1`, `blk_addr = 16 + load_cnt`, `blk_wdata = in_data`. All three are combinational, in the same cycle.
  - `load_cnt` (6 bits) increments on each accepted byte.
  - The accept with `load_cnt == 47` moves to RUN and clears `load_cnt`.
  - Addresses 0–15 (row 0, constants) are never written.
- **RUN**
  - `blk_hold = 0` for exactly `CALC_CYCLES` cycles, counted by `calc_cnt` of width `$clog2(CALC_CYCLES+1)`.
  - When `calc_cnt == CALC_CYCLES - 1`, the next state is UNLOAD.
  - With `CALC_CYCLES == 0`, RUN lasts one cycle with `blk_hold = 1`.
- **UNLOAD**
  - `blk_addr = rd_cnt`, covering 0..63.
  - When `!out_valid || out_ready`: `out_data <= blk_rdata`, `out_valid <= 1`, `rd_cnt++`.
  - After the byte from address 63 has been captured, no further capture happens. `out_valid` drops on the cycle after that byte's handshake.
  - On that handshake: state → LOAD, `blk_rst <= 1` for exactly one cycle, `rd_cnt` cleared.
- `blk_hold = 1` in LOAD and UNLOAD. `blk_write = 0` outside LOAD accepts.
- `out_data` is held stable while `out_valid && !out_ready`.

## Timing

- Reset values (the cycle after `rst` is sampled high):
  - state LOAD; all counters 0.
  - `out_valid = 0`, `out_data = 0`.
  - `blk_hold = 1`, `blk_write = 0`, `blk_rst = 1`, `in_ready = 0`.
- `blk_rst` is registered. It stays high for one cycle after `rst` deasserts, so `in_ready` first rises two cycles after the last `rst` cycle.
- Load has zero latency: a byte accepted in cycle t is written to the slice at the rising edge ending t.
- Best case, the first `out_valid` comes 1 cycle after entering UNLOAD. With `out_ready` held high, throughput is 1 byte/cycle.
- Block time with all ready and valid: 48 load + max(`CALC_CYCLES`, 1) run + 65 unload cycles, plus 1 `blk_rst` cycle.
- `rst` mid-operation: abandon the block immediately. `out_valid` falls, and no further `blk_write` is issued after the reset cycle.
- `in_valid` while not in LOAD: ignored, and `in_ready` stays 0.
- `out_ready` while `!out_valid`: ignored.

## Structure

- Package `chacha_pkg` holds:
  - the state enum `{LOAD, RUN, UNLOAD}`;
  - `LOAD_BASE = 6'd16`, `LOAD_BYTES = 48`, `BLOCK_BYTES = 64`;
  - the address-field slice positions (row 5:4, col 3:2, byte 1:0), shared with the slices.
- One sub-module is natural: `chacha_out_stage`, a one-entry valid/ready output register with load-enable = `!out_valid || out_ready`.

## Test plan

- **Reset.** Hold `rst` 3 cycles. Required: `out_valid = 0`, `blk_hold = 1`, `blk_rst` high through the first post-reset cycle, and `in_ready` first rising 2 cycles after `rst` falls.
- **Load.** Stream bytes 0x00..0x2F with `in_valid` always high. Required: `blk_write` on 48 consecutive cycles, with `blk_addr` 16..63 and `blk_wdata == blk_addr - 16`. Then state RUN.
- **Compute window.** With `CALC_CYCLES = 80`, `blk_hold` must be low for exactly 80 cycles, then UNLOAD.
- **Loopback.** Use 4 behavioural slices with `a_init` set to "expa nd 3 2-by te k" and `CALC_CYCLES = 0`. After loading 0x00..0x2F, require:
  - `out_data` sequence 65 78 70 61 …;
  - bytes 16..63 equal to 0x00..0x2F;
  - 64 handshakes total, then a one-cycle `blk_rst`.
- **Backpressure.** Drive `out_ready` with the pattern 1,0,0,1 repeating. Required: `out_data` stable while stalled, no byte lost or duplicated, 64 bytes delivered in order.
- **Mid-block reset.** Assert `rst` after 20 load bytes, then again after 10 unload bytes. Required: `out_valid` falls, counters return to 0, and the next load starts at `blk_addr` 16.
